clause_sweep_ctrl: RTL and testbench

Sequencer for the clause evaluator datapath in the WalkSAT engine. On request, it sweeps every clause in the clause memory through the evaluator at one clause per cycle and gathers the unsatisfied-clause statistics the flip heuristic needs. Between sweeps it owns the evaluator's truth-table write port and serialises variable flips into it, so sweeps and flips never overlap.

---
 rtl/wsat_pkg.sv | 27 ++
 rtl/eval_tag_pipe.sv | 37 +++
 rtl/clause_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_clause_sweep_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wsat_pkg.sv
// Shared types for the WalkSAT clause sweep logic: literal/clause layout and
// the sweep sequencer state encoding.
package wsat_pkg;

  localparam int DEF_VAR_W = 11;
  localparam int DEF_CLS_W = 12;

  // "var" is a reserved word, so the variable field is var_idx.
  typedef struct packed {
    logic                 neg;
    logic [DEF_VAR_W-1:0] var_idx;
  } literal_t;

  typedef struct packed {
    literal_t lit3;
    literal_t lit2;
    literal_t lit1;
  } clause_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FLIP  = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/eval_tag_pipe.sv
// Shift register of {valid, clause index} that tracks each issued clause
// until the evaluator's sat result for it is due.
module eval_tag_pipe #(
  parameter int IDX_W = 12,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx,
  output logic             pending
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) idx_q[k] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_idx = idx_q[DEPTH-1];
  assign pending = |vld_q;

endmodule

// File: rtl/clause_sweep_ctrl.sv
// Clause sweep sequencer: streams every clause through the evaluator at one
// per cycle, collects unsatisfied-clause statistics, and serialises flips.
module clause_sweep_ctrl
  import wsat_pkg::*;
#(
  parameter int VAR_W       = DEF_VAR_W,
  parameter int CLS_W       = DEF_CLS_W,
  parameter int NUM_CLAUSES = 4096,
  parameter int EVAL_LAT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flip_req,
  input  logic [VAR_W-1:0]   flip_addr,
  input  logic               flip_val,
  output logic               flip_ack,
  output logic               busy,
  output logic               done,
  output logic [CLS_W-1:0]   cls_addr,
  input  logic [3*(VAR_W+1)-1:0] cls_data,
  output logic [VAR_W-1:0]   var_address1,
  output logic [VAR_W-1:0]   var_address2,
  output logic [VAR_W-1:0]   var_address3,
  output logic               neg_bit1,
  output logic               neg_bit2,
  output logic               neg_bit3,
  output logic               write,
  output logic [VAR_W-1:0]   flip_var_address,
  output logic               flip_value,
  input  logic               sat,
  output logic [CLS_W:0]     unsat_count,
  output logic [CLS_W-1:0]   first_unsat,
  output logic               first_unsat_vld,
  output logic               all_sat
);

  localparam int              LIT_W    = VAR_W + 1;
  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLAUSES - 1);

  // Handshakes: start is a level held until busy is seen high; flip_req is a
  // level held until the single-cycle flip_ack. Neither is accepted while a
  // sweep is running or during its done cycle.
  sweep_state_e           state_q, state_d;
  logic [CLS_W-1:0]       index_q;
  logic                   fetch_q;
  logic                   done_q;
  logic                   sweep_go;
  logic [3*LIT_W-1:0]     lits_q;
  logic                   tag_vld;
  logic [CLS_W-1:0]       tag_idx;
  logic                   tag_pending;
  logic                   drained;

  assign drained = (state_q == DRAIN) && !tag_pending;

  always_comb begin
    state_d          = state_q;
    sweep_go         = 1'b0;
    cls_addr         = '0;
    write            = 1'b0;
    flip_ack         = 1'b0;
    flip_var_address = '0;
    flip_value       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!done_q) begin
          if (flip_req) begin
            state_d = FLIP;
          end else if (start) begin
            state_d  = FETCH;
            sweep_go = 1'b1;
          end
        end
      end
      FETCH: begin
        cls_addr = index_q;
        if (index_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        if (!tag_pending) state_d = IDLE;
      end
      FLIP: begin
        write            = 1'b1;
        flip_ack         = 1'b1;
        flip_var_address = flip_addr;
        flip_value       = flip_val;
        // A start held alongside the flip is taken right away.
        if (start) begin
          state_d  = FETCH;
          sweep_go = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      index_q         <= '0;
      fetch_q         <= 1'b0;
      done_q          <= 1'b0;
      lits_q          <= '0;
      unsat_count     <= '0;
      first_unsat     <= '0;
      first_unsat_vld <= 1'b0;
      all_sat         <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= (state_q == FETCH);
      done_q  <= drained;
      if (sweep_go) begin
        index_q <= '0;
      end else if (state_q == FETCH && index_q != LAST_IDX) begin
        index_q <= index_q + 1'b1;
      end
      // Clause memory data arrives the cycle after its address was issued.
      if (fetch_q) lits_q <= cls_data;
      if (sweep_go) begin
        unsat_count     <= '0;
        first_unsat     <= '0;
        first_unsat_vld <= 1'b0;
        all_sat         <= 1'b0;
      end else begin
        if (tag_vld && !sat) begin
          unsat_count <= unsat_count + 1'b1;
          if (!first_unsat_vld) begin
            first_unsat     <= tag_idx;
            first_unsat_vld <= 1'b1;
          end
        end
        if (drained) all_sat <= (unsat_count == '0);
      end
    end
  end

  eval_tag_pipe #(
    .IDX_W (CLS_W),
    .DEPTH (1 + EVAL_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (state_q == FETCH),
    .in_idx  (index_q),
    .out_vld (tag_vld),
    .out_idx (tag_idx),
    .pending (tag_pending)
  );

  assign var_address1 = lits_q[VAR_W-1:0];
  assign neg_bit1     = lits_q[VAR_W];
  assign var_address2 = lits_q[LIT_W +: VAR_W];
  assign neg_bit2     = lits_q[LIT_W + VAR_W];
  assign var_address3 = lits_q[2*LIT_W +: VAR_W];
  assign neg_bit3     = lits_q[2*LIT_W + VAR_W];

  assign busy = (state_q == FETCH) || (state_q == DRAIN) || done_q;
  assign done = done_q;

endmodule

// File: tb/tb_clause_sweep_ctrl.sv
// Bench for clause_sweep_ctrl: clause memory and evaluator models, directed
// sweeps and flips, scoreboard queues drained by negedge monitors.
module tb_clause_sweep_ctrl;
  import wsat_pkg::*;

  localparam int VAR_W = 11;
  localparam int CLS_W = 12;
  localparam int N     = 8;
  localparam int L     = 2;

  logic               clk;
  logic               rst;
  logic               start;
  logic               flip_req;
  logic [VAR_W-1:0]   flip_addr;
  logic               flip_val;
  logic               flip_ack;
  logic               busy;
  logic               done;
  logic [CLS_W-1:0]   cls_addr;
  logic [3*(VAR_W+1)-1:0] cls_data;
  logic [VAR_W-1:0]   var_address1, var_address2, var_address3;
  logic               neg_bit1, neg_bit2, neg_bit3;
  logic               write;
  logic [VAR_W-1:0]   flip_var_address;
  logic               flip_value;
  logic               sat;
  logic [CLS_W:0]     unsat_count;
  logic [CLS_W-1:0]   first_unsat;
  logic               first_unsat_vld;
  logic               all_sat;

  clause_sweep_ctrl #(
    .VAR_W(VAR_W), .CLS_W(CLS_W), .NUM_CLAUSES(N), .EVAL_LAT(L)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .flip_req(flip_req),
    .flip_addr(flip_addr), .flip_val(flip_val), .flip_ack(flip_ack),
    .busy(busy), .done(done), .cls_addr(cls_addr), .cls_data(cls_data),
    .var_address1(var_address1), .var_address2(var_address2),
    .var_address3(var_address3), .neg_bit1(neg_bit1), .neg_bit2(neg_bit2),
    .neg_bit3(neg_bit3), .write(write), .flip_var_address(flip_var_address),
    .flip_value(flip_value), .sat(sat), .unsat_count(unsat_count),
    .first_unsat(first_unsat), .first_unsat_vld(first_unsat_vld),
    .all_sat(all_sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

  // ---------------- clause memory + evaluator models ----------------
  function automatic clause_t mk_clause(input int i);
    clause_t c;
    c.lit1.var_idx = VAR_W'(i);
    c.lit1.neg     = i[0];
    c.lit2.var_idx = VAR_W'(i + 100);
    c.lit2.neg     = i[1];
    c.lit3.var_idx = VAR_W'(3 * i + 7);
    c.lit3.neg     = ~i[2];
    return c;
  endfunction

  always @(posedge clk) cls_data <= mk_clause(int'(cls_addr));

  logic [7:0] unsat_mask;
  clause_t    ev_d = '0;
  always @(posedge clk)
    ev_d <= {neg_bit3, var_address3, neg_bit2, var_address2, neg_bit1, var_address1};
  // A clause is reported satisfied only if all three literals arrived intact.
  assign sat = (ev_d == mk_clause(int'(ev_d.lit1.var_idx))) &&
               !unsat_mask[ev_d.lit1.var_idx[2:0]];

  // ---------------- scoreboard ----------------
  logic [26:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [12:0] flip_q[$];
  int checks = 0;
  int passes = 0;
  int last_done_cyc = -1;
  int max_addr = 0;
  int write_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [26:0] res(input int cnt, input int first, input bit vld, input bit alls);
    return {13'(cnt), 12'(first), vld, alls};
  endfunction

  always @(negedge clk) begin
    if (int'(cls_addr) > max_addr) max_addr = int'(cls_addr);
    if (write !== flip_ack) write_bad++;
    if (done === 1'b1) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) check("done_expected", 64'(exp_q.size()), 1);
      else begin
        check("sweep_results", {unsat_count, first_unsat, first_unsat_vld, all_sat}, exp_q.pop_front());
        check("done_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    if (flip_ack === 1'b1) begin
      if (flip_q.size() == 0) check("flip_expected", 64'(flip_q.size()), 1);
      else check("flip_write", {write, flip_var_address, flip_value}, flip_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(output int c1, output bit ok);
    ok = 1'b0;
    c1 = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        c1 = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(seen), 1);
  endtask

  task automatic wait_ack(output int ack_c);
    bit seen = 1'b0;
    ack_c = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (flip_ack === 1'b1) begin
        seen  = 1'b1;
        ack_c = cyc;
        break;
      end
    end
    check("flip_ack_seen", 64'(seen), 1);
  endtask

  task automatic begin_sweep(input logic [7:0] mask, input bit expect_done,
                             input logic [26:0] exp, output int c1);
    bit ok;
    tick();
    unsat_mask = mask;
    if (expect_done) exp_q.push_back(exp);
    start = 1'b1;
    wait_busy(c1, ok);
    check("start_accepted", 64'(ok), 1);
    if (expect_done) exp_cyc_q.push_back(c1 + N + 2 + L);
    tick();
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {flip_ack, busy, done, write, flip_var_address, flip_value, cls_addr}, 0);
    check({tag, "_lits"}, {neg_bit3, var_address3, neg_bit2, var_address2, neg_bit1, var_address1}, 0);
    check({tag, "_results"}, {unsat_count, first_unsat, first_unsat_vld, all_sat}, 0);
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0]  masks [4] = '{8'h48, 8'h00, 8'h81, 8'hFF};
  logic [26:0] exps  [4];

  initial begin
    int c1, c1b, r, ack_c, bad;
    bit ok;
    exps[0] = res(2, 3, 1'b1, 1'b0);
    exps[1] = res(0, 0, 1'b0, 1'b1);
    exps[2] = res(2, 0, 1'b1, 1'b0);
    exps[3] = res(8, 0, 1'b1, 1'b0);
    rst = 1'b0; start = 1'b0; flip_req = 1'b0;
    flip_addr = 11'h155; flip_val = 1'b1; unsat_mask = 8'h00;
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset");
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (write !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_write_low", bad, 0);

    for (int k = 0; k < 4; k++) begin
      begin_sweep(masks[k], 1'b1, exps[k], c1);
      wait_done();
    end

    // start and flip_req together: flip wins, sweep follows immediately
    tick();
    unsat_mask = 8'hC0;
    exp_q.push_back(res(2, 6, 1'b1, 1'b0));
    flip_q.push_back({1'b1, 11'h005, 1'b1});
    flip_addr = 11'h005; flip_val = 1'b1; flip_req = 1'b1; start = 1'b1;
    r = cyc;
    wait_ack(ack_c);
    check("flip_first_cycle", ack_c, r + 1);
    tick();
    flip_req = 1'b0;
    wait_busy(c1, ok);
    check("sweep_after_flip", c1, r + 2);
    exp_cyc_q.push_back(c1 + N + 2 + L);
    tick();
    start = 1'b0;
    wait_done();

    // flip raised mid-sweep waits for done
    begin_sweep(8'h00, 1'b1, res(0, 0, 1'b0, 1'b1), c1);
    tick();
    flip_addr = 11'h2AA; flip_val = 1'b0;
    flip_q.push_back({1'b1, 11'h2AA, 1'b0});
    flip_req = 1'b1;
    wait_ack(ack_c);
    check("flip_after_done", ack_c, last_done_cyc + 2);
    tick();
    flip_req = 1'b0;

    // reset during cycle 4 of a sweep
    begin_sweep(8'h0F, 1'b0, '0, c1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    check("no_done_after_abort", bad, 0);
    begin_sweep(8'h22, 1'b1, res(2, 1, 1'b1, 1'b0), c1);
    wait_done();

    // back-to-back sweeps with start held
    tick();
    unsat_mask = 8'h48;
    exp_q.push_back(exps[0]);
    exp_q.push_back(exps[0]);
    start = 1'b1;
    wait_busy(c1, ok);
    check("b2b_first_accept", 64'(ok), 1);
    exp_cyc_q.push_back(c1 + N + 2 + L);
    wait_done();
    wait_busy(c1b, ok);
    check("b2b_restart_cycle", c1b, last_done_cyc + 2);
    exp_cyc_q.push_back(c1b + N + 2 + L);
    tick();
    start = 1'b0;
    wait_done();

    repeat (3) tick();
    check("max_cls_addr", max_addr, N - 1);
    check("write_only_with_ack", write_bad, 0);
    check("sweep_queue_drained", 64'(exp_q.size()), 0);
    check("flip_queue_drained", 64'(flip_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
